tlb_port_sched: RTL and testbench

//  Sequences a shared MMU/TLB port between two lookup requesters (0 = ifetch, 1 = data) and one refill source.

---
 rtl/tlb_port_sched_if.sv | 65 ++++++
 rtl/tlb_port_sched.sv | 185 ++++++++++++++++++
 tb/tb_tlb_port_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_port_sched_if.sv
//------------------------------------------------------------------------------
// tlb_port_sched_if : requester / refill / flush / MMU bundle for tlb_port_sched
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tlb_port_sched_if #(
  parameter int SADDR = 64,
  parameter int SPCID = 12
);
  // Lookup requesters (0 = ifetch, 1 = data), packed per requester
  logic [1:0]         req_valid;
  logic [2*SADDR-1:0] req_va;
  logic [2*SPCID-1:0] req_pcid;
  logic [1:0]         req_ready;
  logic [1:0]         rsp_valid;
  logic               rsp_hit;
  logic [SADDR-1:0]   rsp_pa;

  logic               fill_valid;
  logic [SADDR-1:0]   fill_va;
  logic [SADDR-1:0]   fill_pa;
  logic [SPCID-1:0]   fill_pcid;
  logic               fill_ready;

  logic               flush_req;
  logic               flush_done;

  // MMU side
  logic               tlb_validate;
  logic               tlb_insert;
  logic               tlb_shutdown;
  logic [SADDR-1:0]   tlb_va;
  logic [SADDR-1:0]   tlb_pa;
  logic [SPCID-1:0]   tlb_pcid;
  logic [SADDR-1:0]   tlb_ta;
  logic               tlb_hit;
  logic               tlb_miss;

  // Scheduler view
  modport slave (
    input  req_valid, req_va, req_pcid,
    output req_ready, rsp_valid, rsp_hit, rsp_pa,
    input  fill_valid, fill_va, fill_pa, fill_pcid,
    output fill_ready,
    input  flush_req,
    output flush_done,
    output tlb_validate, tlb_insert, tlb_shutdown, tlb_va, tlb_pa, tlb_pcid,
    input  tlb_ta, tlb_hit, tlb_miss
  );

  // Environment view (requesters, page walker, MMU)
  modport master (
    output req_valid, req_va, req_pcid,
    input  req_ready, rsp_valid, rsp_hit, rsp_pa,
    output fill_valid, fill_va, fill_pa, fill_pcid,
    input  fill_ready,
    output flush_req,
    input  flush_done,
    input  tlb_validate, tlb_insert, tlb_shutdown, tlb_va, tlb_pa, tlb_pcid,
    output tlb_ta, tlb_hit, tlb_miss
  );
endinterface

`default_nettype wire

// File: rtl/tlb_port_sched.sv
//------------------------------------------------------------------------------
// tlb_port_sched : single-op scheduler for a shared MMU/TLB port
//                  (flush > fill > round-robin lookup)
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tlb_port_sched #(
  parameter int SADDR     = 64,
  parameter int SPCID     = 12,
  parameter int INS_CYC   = 2,
  parameter int FLUSH_CYC = 1,
  parameter int TIMEOUT   = 15
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  tlb_port_sched_if.slave   bus
);

  localparam int C_MAXV = (INS_CYC > FLUSH_CYC)
                        ? ((INS_CYC > TIMEOUT) ? INS_CYC : TIMEOUT)
                        : ((FLUSH_CYC > TIMEOUT) ? FLUSH_CYC : TIMEOUT);
  localparam int C_CW   = $clog2(C_MAXV + 1);

  localparam logic [C_CW-1:0] C_CNT_MAX    = {C_CW{1'b1}};
  localparam logic [C_CW-1:0] C_INS_LAST   = C_CW'(INS_CYC - 1);
  localparam logic [C_CW-1:0] C_FLUSH_LAST = C_CW'(FLUSH_CYC - 1);
  // Counter holds LOOK cycles already spent, so LOOK lasts at most TIMEOUT cycles
  localparam logic [C_CW-1:0] C_TO_LAST    = C_CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_FILL  = 2'd2,
    S_LOOK  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              gnt_q, gnt_d;
  logic [C_CW-1:0]   cnt_q, cnt_d;
  logic [SADDR-1:0]  tlb_va_q, tlb_va_d;
  logic [SADDR-1:0]  tlb_pa_q, tlb_pa_d;
  logic [SPCID-1:0]  tlb_pcid_q, tlb_pcid_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic [SADDR-1:0]  rsp_pa_q, rsp_pa_d;

  logic [1:0]        w_ready;
  logic              w_gnt;
  logic              w_validate;
  logic              w_insert;
  logic              w_shutdown;
  logic              w_fill_ready;
  logic              w_flush_done;
  logic [C_CW-1:0]   w_cnt_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      tlb_va_q    <= '0;
      tlb_pa_q    <= '0;
      tlb_pcid_q  <= '0;
      rsp_valid_q <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_pa_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      tlb_va_q    <= tlb_va_d;
      tlb_pa_q    <= tlb_pa_d;
      tlb_pcid_q  <= tlb_pcid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_pa_q    <= rsp_pa_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    tlb_va_d     = tlb_va_q;
    tlb_pa_d     = tlb_pa_q;
    tlb_pcid_d   = tlb_pcid_q;
    rsp_valid_d  = '0;
    rsp_hit_d    = rsp_hit_q;
    rsp_pa_d     = rsp_pa_q;
    w_ready      = '0;
    w_gnt        = rr_q;
    w_validate   = 1'b0;
    w_insert     = 1'b0;
    w_shutdown   = 1'b0;
    w_fill_ready = 1'b0;
    w_flush_done = 1'b0;
    w_cnt_inc    = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.flush_req) begin
          state_d = S_FLUSH;
        end else if (bus.fill_valid) begin
          tlb_va_d   = bus.fill_va;
          tlb_pa_d   = bus.fill_pa;
          tlb_pcid_d = bus.fill_pcid;
          state_d    = S_FILL;
        end else if (|bus.req_valid) begin
          // Pointer owner wins if asking, otherwise the other requester
          w_gnt          = bus.req_valid[rr_q] ? rr_q : ~rr_q;
          w_ready[w_gnt] = 1'b1;
          tlb_va_d       = w_gnt ? bus.req_va[2*SADDR-1:SADDR]   : bus.req_va[SADDR-1:0];
          tlb_pcid_d     = w_gnt ? bus.req_pcid[2*SPCID-1:SPCID] : bus.req_pcid[SPCID-1:0];
          tlb_pa_d       = '0;
          gnt_d          = w_gnt;
          rr_d           = ~w_gnt;
          state_d        = S_LOOK;
        end
      end

      S_FLUSH: begin
        w_shutdown = 1'b1;
        if (cnt_q == C_FLUSH_LAST) begin
          w_flush_done = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end

      S_FILL: begin
        w_insert = 1'b1;
        if (cnt_q == C_INS_LAST) begin
          w_fill_ready = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end

      S_LOOK: begin
        w_validate = 1'b1;
        if (bus.tlb_hit) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_hit_d          = 1'b1;
          rsp_pa_d           = bus.tlb_ta;
          state_d            = S_IDLE;
        end else if (bus.tlb_miss || (cnt_q == C_TO_LAST)) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_hit_d          = 1'b0;
          rsp_pa_d           = '0;
          state_d            = S_IDLE;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Pulses and strobes are suppressed in a reset cycle so an abandoned op never reports
  assign bus.req_ready    = w_ready & {2{rst_n}};
  assign bus.tlb_validate = w_validate & rst_n;
  assign bus.tlb_insert   = w_insert & rst_n;
  assign bus.tlb_shutdown = w_shutdown & rst_n;
  assign bus.fill_ready   = w_fill_ready & rst_n;
  assign bus.flush_done   = w_flush_done & rst_n;

  assign bus.tlb_va    = tlb_va_q;
  assign bus.tlb_pa    = tlb_pa_q;
  assign bus.tlb_pcid  = tlb_pcid_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_pa    = rsp_pa_q;

endmodule

`default_nettype wire

// File: tb/tb_tlb_port_sched.sv
//------------------------------------------------------------------------------
// tb_tlb_port_sched : directed bench for tlb_port_sched
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tlb_port_sched;
  localparam int SADDR = 64;
  localparam int SPCID = 12;
  localparam logic [SADDR-1:0] C_FV = 64'hffff_ffff_ffff_fff1;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  tlb_port_sched_if #(.SADDR(SADDR), .SPCID(SPCID)) bus ();

  tlb_port_sched #(
    .SADDR(SADDR), .SPCID(SPCID), .INS_CYC(2), .FLUSH_CYC(1), .TIMEOUT(15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid  = '0;
    bus.req_va     = '0;
    bus.req_pcid   = '0;
    bus.fill_valid = 1'b0;
    bus.fill_va    = '0;
    bus.fill_pa    = '0;
    bus.fill_pcid  = '0;
    bus.flush_req  = 1'b0;
    bus.tlb_ta     = '0;
    bus.tlb_hit    = 1'b0;
    bus.tlb_miss   = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] flags;
    rst_n = 1'b0;
    idle_inputs();
    bus.req_valid = 2'b11;
    bus.flush_req = 1'b1;
    bus.fill_valid = 1'b1;
    cyc();
    cyc();
    #1;
    flags = {bus.tlb_validate, bus.tlb_insert, bus.tlb_shutdown, bus.fill_ready,
             bus.flush_done, bus.req_ready, bus.rsp_valid, bus.rsp_hit};
    checks++;
    if (flags !== 10'd0) begin
      errors++; $display("FAIL reset_flags: got %b want 0", flags);
    end
    checks++;
    if ({bus.rsp_pa, bus.tlb_va, bus.tlb_pa, bus.tlb_pcid} !== '0) begin
      errors++; $display("FAIL reset_data: got va=%h pa=%h pcid=%h rsp_pa=%h want 0",
                         bus.tlb_va, bus.tlb_pa, bus.tlb_pcid, bus.rsp_pa);
    end
    cyc();
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_flush();
    bus.flush_req = 1'b1;
    #1;
    checks++;
    if (bus.tlb_shutdown !== 1'b0) begin
      errors++; $display("FAIL flush_idle: shutdown got %b want 0", bus.tlb_shutdown);
    end
    cyc();
    bus.flush_req = 1'b0;
    #1;
    checks++;
    if ({bus.tlb_shutdown, bus.flush_done} !== 2'b11) begin
      errors++; $display("FAIL flush_active: shutdown,done got %b want 11",
                         {bus.tlb_shutdown, bus.flush_done});
    end
    cyc();
    #1;
    checks++;
    if ({bus.tlb_shutdown, bus.flush_done} !== 2'b00) begin
      errors++; $display("FAIL flush_end: shutdown,done got %b want 00",
                         {bus.tlb_shutdown, bus.flush_done});
    end
  endtask

  task automatic test_fill();
    logic exp_rdy;
    bus.fill_valid = 1'b1;
    bus.fill_va    = C_FV;
    bus.fill_pa    = '0;
    bus.fill_pcid  = '0;
    #1;
    checks++;
    if (bus.tlb_insert !== 1'b0) begin
      errors++; $display("FAIL fill_idle: insert got %b want 0", bus.tlb_insert);
    end
    for (int c = 0; c < 2; c++) begin
      cyc();
      #1;
      exp_rdy = (c == 1);
      checks++;
      if ({bus.tlb_insert, bus.fill_ready} !== {1'b1, exp_rdy}) begin
        errors++; $display("FAIL fill_cycle%0d: insert,ready got %b want %b",
                           c, {bus.tlb_insert, bus.fill_ready}, {1'b1, exp_rdy});
      end
      checks++;
      if (bus.tlb_va !== C_FV || bus.tlb_pa !== '0 || bus.tlb_pcid !== '0) begin
        errors++; $display("FAIL fill_operands%0d: got va=%h pa=%h pcid=%h want va=%h pa=0 pcid=0",
                           c, bus.tlb_va, bus.tlb_pa, bus.tlb_pcid, C_FV);
      end
    end
    bus.fill_valid = 1'b0;
    cyc();
    #1;
    checks++;
    if ({bus.tlb_insert, bus.fill_ready} !== 2'b00) begin
      errors++; $display("FAIL fill_end: insert,ready got %b want 00",
                         {bus.tlb_insert, bus.fill_ready});
    end
  endtask

  task automatic test_reset_mid_fill();
    bus.fill_valid = 1'b1;
    bus.fill_va    = 64'h0000_0000_dead_b000;
    bus.fill_pa    = 64'h0000_0000_0abc_d000;
    bus.fill_pcid  = 12'h005;
    cyc();
    #1;
    checks++;
    if (bus.tlb_insert !== 1'b1) begin
      errors++; $display("FAIL rstfill_ins1: insert got %b want 1", bus.tlb_insert);
    end
    cyc();
    rst_n = 1'b0;
    bus.fill_valid = 1'b0;
    #1;
    checks++;
    if (bus.fill_ready !== 1'b0) begin
      errors++; $display("FAIL rstfill_ready: fill_ready got %b want 0", bus.fill_ready);
    end
    cyc();
    #1;
    checks++;
    if (bus.tlb_insert !== 1'b0 || bus.fill_ready !== 1'b0 || bus.tlb_va !== '0) begin
      errors++; $display("FAIL rstfill_after: insert=%b ready=%b va=%h want 0 0 0",
                         bus.tlb_insert, bus.fill_ready, bus.tlb_va);
    end
    rst_n = 1'b1;
    cyc();
    #1;
    checks++;
    if ({bus.tlb_insert, bus.fill_ready, bus.tlb_shutdown, bus.tlb_validate} !== 4'b0000) begin
      errors++; $display("FAIL rstfill_idle: insert,ready,shutdown,validate got %b want 0000",
                         {bus.tlb_insert, bus.fill_ready, bus.tlb_shutdown, bus.tlb_validate});
    end
  endtask

  task automatic test_lookup_hit();
    bus.req_va    = {C_FV, 64'h0};
    bus.req_pcid  = '0;
    bus.req_valid = 2'b10;
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++; $display("FAIL hit_grant: req_ready got %b want 10", bus.req_ready);
    end
    cyc();
    bus.req_valid = 2'b00;
    bus.tlb_hit   = 1'b1;
    bus.tlb_ta    = 64'h1;
    #1;
    checks++;
    if (bus.tlb_validate !== 1'b1 || bus.tlb_va !== C_FV || bus.tlb_pcid !== '0 ||
        bus.tlb_pa !== '0 || bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL hit_look: validate=%b va=%h pcid=%h pa=%h rsp_valid=%b want 1 %h 0 0 00",
                         bus.tlb_validate, bus.tlb_va, bus.tlb_pcid, bus.tlb_pa, bus.rsp_valid, C_FV);
    end
    cyc();
    bus.tlb_hit = 1'b0;
    bus.tlb_ta  = '0;
    #1;
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_hit !== 1'b1 || bus.rsp_pa !== 64'h1) begin
      errors++; $display("FAIL hit_rsp: rsp_valid=%b hit=%b pa=%h want 10 1 1",
                         bus.rsp_valid, bus.rsp_hit, bus.rsp_pa);
    end
    cyc();
    #1;
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL hit_rsp_pulse: rsp_valid got %b want 00", bus.rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]       exp_rdy;
    logic [SADDR-1:0] exp_va;
    logic             exp_hit;
    bus.req_va    = {C_FV, 64'h0000_0000_0000_1000};
    bus.req_pcid  = {12'h000, 12'h001};
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_va  = (k % 2 == 0) ? 64'h0000_0000_0000_1000 : C_FV;
      exp_hit = (k % 2 == 1);
      #1;
      checks++;
      if (bus.req_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_grant%0d: req_ready got %b want %b", k, bus.req_ready, exp_rdy);
      end
      cyc();
      // Small MMU model: PCID 1 misses, anything else hits with ta=1
      if (bus.tlb_pcid == 12'h001) bus.tlb_miss = 1'b1;
      else begin bus.tlb_hit = 1'b1; bus.tlb_ta = 64'h1; end
      #1;
      checks++;
      if (bus.tlb_validate !== 1'b1 || bus.tlb_va !== exp_va) begin
        errors++; $display("FAIL rr_look%0d: validate=%b va=%h want 1 %h",
                           k, bus.tlb_validate, bus.tlb_va, exp_va);
      end
      cyc();
      bus.tlb_hit  = 1'b0;
      bus.tlb_miss = 1'b0;
      bus.tlb_ta   = '0;
      if (k == 3) bus.req_valid = 2'b00;
      #1;
      checks++;
      if (bus.rsp_valid !== exp_rdy || bus.rsp_hit !== exp_hit ||
          bus.rsp_pa !== (exp_hit ? 64'h1 : 64'h0)) begin
        errors++; $display("FAIL rr_rsp%0d: rsp_valid=%b hit=%b pa=%h want %b %b %h",
                           k, bus.rsp_valid, bus.rsp_hit, bus.rsp_pa, exp_rdy, exp_hit,
                           exp_hit ? 64'h1 : 64'h0);
      end
    end
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++; $display("FAIL rr_stop: req_ready got %b want 00", bus.req_ready);
    end
  endtask

  task automatic test_busy_priority();
    int n = 0;
    int side = 0;
    bus.req_va    = {64'h0, 64'h0000_0000_0000_2000};
    bus.req_pcid  = {12'h000, 12'h003};
    bus.req_valid = 2'b01;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL busy_grant: req_ready got %b want 01", bus.req_ready);
    end
    cyc();
    bus.req_valid  = 2'b00;
    bus.fill_valid = 1'b1;
    bus.fill_va    = 64'h0000_0000_abcd_0000;
    bus.fill_pa    = 64'h0000_0000_1234_5000;
    bus.fill_pcid  = 12'h007;
    bus.flush_req  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.tlb_validate !== 1'b1) break;
      n++;
      if (bus.rsp_valid !== 2'b00 || bus.tlb_shutdown !== 1'b0 || bus.tlb_insert !== 1'b0) side++;
      cyc();
    end
    checks++;
    if (n != 15) begin
      errors++; $display("FAIL busy_timeout: LOOK cycles got %0d want 15", n);
    end
    checks++;
    if (side != 0) begin
      errors++; $display("FAIL busy_preempt: cycles with early rsp/strobe got %0d want 0", side);
    end
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_hit !== 1'b0 || bus.rsp_pa !== '0 ||
        bus.tlb_shutdown !== 1'b0) begin
      errors++; $display("FAIL busy_rsp: rsp_valid=%b hit=%b pa=%h shutdown=%b want 01 0 0 0",
                         bus.rsp_valid, bus.rsp_hit, bus.rsp_pa, bus.tlb_shutdown);
    end
    cyc();
    bus.flush_req = 1'b0;
    #1;
    checks++;
    if ({bus.tlb_shutdown, bus.flush_done, bus.tlb_insert} !== 3'b110) begin
      errors++; $display("FAIL busy_flush: shutdown,done,insert got %b want 110",
                         {bus.tlb_shutdown, bus.flush_done, bus.tlb_insert});
    end
    cyc();
    #1;
    checks++;
    if ({bus.tlb_shutdown, bus.tlb_insert} !== 2'b00) begin
      errors++; $display("FAIL busy_gap: shutdown,insert got %b want 00",
                         {bus.tlb_shutdown, bus.tlb_insert});
    end
    cyc();
    #1;
    checks++;
    if (bus.tlb_insert !== 1'b1 || bus.tlb_va !== 64'h0000_0000_abcd_0000 ||
        bus.tlb_pa !== 64'h0000_0000_1234_5000 || bus.tlb_pcid !== 12'h007) begin
      errors++; $display("FAIL busy_fill: insert=%b va=%h pa=%h pcid=%h want 1 abcd0000 12345000 007",
                         bus.tlb_insert, bus.tlb_va, bus.tlb_pa, bus.tlb_pcid);
    end
    cyc();
    #1;
    checks++;
    if ({bus.tlb_insert, bus.fill_ready} !== 2'b11) begin
      errors++; $display("FAIL busy_fill_done: insert,ready got %b want 11",
                         {bus.tlb_insert, bus.fill_ready});
    end
    bus.fill_valid = 1'b0;
    cyc();
    #1;
    checks++;
    if ({bus.tlb_insert, bus.fill_ready} !== 2'b00) begin
      errors++; $display("FAIL busy_end: insert,ready got %b want 00",
                         {bus.tlb_insert, bus.fill_ready});
    end
  endtask

  initial begin
    test_reset();
    test_flush();
    test_fill();
    test_reset_mid_fill();
    test_lookup_hit();
    test_back_to_back();
    test_busy_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
